// File: rtl/ula_seq_if.sv
// Operand/result bus and start/busy/done handshake between the control unit and ula_seq.
interface ula_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] T;
    logic [WIDTH-1:0] Y;
    logic [4:0]       funct;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Result;
    logic [WIDTH-1:0] ResultHi;
    logic             flagC;
    logic             flagZ;
    logic             flagN;
    logic             flagDZ;

    modport master (output start, T, Y, funct,
                    input  busy, done, Result, ResultHi, flagC, flagZ, flagN, flagDZ);
    modport slave  (input  start, T, Y, funct,
                    output busy, done, Result, ResultHi, flagC, flagZ, flagN, flagDZ);
endinterface

// File: rtl/ula_seq.sv
// Clocked stack-CPU ALU: single-cycle logic/add/sub, iterative shift-add MULT and
// restoring DIV (one bit per cycle), double-width result and C/Z/N/DZ flags.
module ula_seq #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic     clk,
    input  logic     reset_n,
    ula_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ITER, FIN} state_e;
    typedef enum logic [1:0] {K_ALU, K_MUL, K_DIV} kind_e;

    state_e           state_q, state_d;
    kind_e            kind;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic [WIDTH:0]   add_sum;
    logic             accept, dz_now;

    // a: product high half / partial remainder, b: multiplier / dividend-quotient, m: operand
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, m_q, m_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             div_q, div_d;
    logic [WIDTH-1:0] a_st, b_st;
    logic [WIDTH:0]   mul_sum, div_r, div_diff;
    logic             div_ge;

    logic [WIDTH-1:0] res_q, res_d, hi_q, hi_d;
    logic             c_q, c_d, z_q, z_d, n_q, n_d, dz_q, dz_d;
    logic             fin_ld, fin_c, fin_dz;
    logic [WIDTH-1:0] fin_res, fin_hi;

    // Exact logic codes first; low two bits then select MULT/DIV, else BYPASST.
    always_comb begin
        kind    = K_ALU;
        alu_res = bus.T;
        alu_c   = 1'b0;
        add_sum = {1'b0, bus.T} + {1'b0, bus.Y};
        casez (bus.funct)
            5'b00100: alu_res = bus.T & bus.Y;
            5'b01000: begin alu_res = bus.T - bus.Y; alu_c = (bus.T < bus.Y); end
            5'b01100: alu_res = bus.T | bus.Y;
            5'b10000: begin alu_res = add_sum[WIDTH-1:0]; alu_c = add_sum[WIDTH]; end
            5'b10100: alu_res = bus.T ^ bus.Y;
            5'b11000: begin alu_res = bus.Y - bus.T; alu_c = (bus.Y < bus.T); end
            5'b11100: alu_res = bus.Y;
            5'b???10: kind = K_MUL;
            5'b???01: kind = K_DIV;
            default:  ;
        endcase
    end

    assign accept = (state_q == IDLE) && bus.start;
    assign dz_now = (kind == K_DIV) && (bus.Y == '0);

    always_comb begin
        mul_sum  = {1'b0, a_q} + (b_q[0] ? {1'b0, m_q} : '0);
        div_r    = {a_q, b_q[WIDTH-1]};
        div_diff = div_r - {1'b0, m_q};
        div_ge   = (div_r >= {1'b0, m_q});
        if (div_q) begin
            a_st = div_ge ? div_diff[WIDTH-1:0] : div_r[WIDTH-1:0];
            b_st = {b_q[WIDTH-2:0], div_ge};
        end else begin
            a_st = mul_sum[WIDTH:1];
            b_st = {mul_sum[0], b_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = (kind == K_ALU || dz_now) ? FIN : ITER;
            ITER:    if (cnt_q == CNT_W'(1)) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state_q == ITER);
        bus.done = (state_q == FIN);
    end

    // Output registers are loaded on the edge entering FIN, so they are valid with done.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        fin_ld  = 1'b0;
        fin_res = b_st;
        fin_hi  = a_st;
        fin_c   = 1'b0;
        fin_dz  = 1'b0;
        if (accept) begin
            a_d   = '0;
            div_d = (kind == K_DIV);
            b_d   = (kind == K_DIV) ? bus.T : bus.Y;
            m_d   = (kind == K_DIV) ? bus.Y : bus.T;
            cnt_d = CNT_W'(WIDTH);
            if (kind == K_ALU) begin
                fin_ld  = 1'b1;
                fin_res = alu_res;
                fin_hi  = '0;
                fin_c   = alu_c;
            end else if (dz_now) begin
                fin_ld  = 1'b1;
                fin_res = '1;
                fin_hi  = bus.T;
                fin_dz  = 1'b1;
            end
        end else if (state_q == ITER) begin
            a_d   = a_st;
            b_d   = b_st;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                fin_ld = 1'b1;
                fin_c  = !div_q && (a_st != '0);
            end
        end

        res_d = res_q;
        hi_d  = hi_q;
        c_d   = c_q;
        z_d   = z_q;
        n_d   = n_q;
        dz_d  = dz_q;
        if (fin_ld) begin
            res_d = fin_res;
            hi_d  = fin_hi;
            c_d   = fin_c;
            dz_d  = fin_dz;
            z_d   = (fin_res == '0);
            n_d   = fin_res[WIDTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            a_q   <= '0;
            b_q   <= '0;
            m_q   <= '0;
            cnt_q <= '0;
            div_q <= 1'b0;
            res_q <= '0;
            hi_q  <= '0;
            c_q   <= 1'b0;
            z_q   <= 1'b0;
            n_q   <= 1'b0;
            dz_q  <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            m_q   <= m_d;
            cnt_q <= cnt_d;
            div_q <= div_d;
            res_q <= res_d;
            hi_q  <= hi_d;
            c_q   <= c_d;
            z_q   <= z_d;
            n_q   <= n_d;
            dz_q  <= dz_d;
        end
    end

    assign bus.Result   = res_q;
    assign bus.ResultHi = hi_q;
    assign bus.flagC    = c_q;
    assign bus.flagZ    = z_q;
    assign bus.flagN    = n_q;
    assign bus.flagDZ   = dz_q;
endmodule

// File: doc/ula_seq.md
Name: ula_seq

Overview:
- Parametrised, clocked successor of the stack-CPU ALU: same 5-bit funct encoding, operand width set by WIDTH.
- Logic ops complete in one cycle. MULT and DIV run iteratively as shift-add and restoring divide, one bit per cycle.
- Produces a double-width result (high half on ResultHi) plus carry, zero, negative and divide-by-zero flags.
- Sits between the data-stack top (T) and the Y bus; the control unit drives it through a start/busy/done handshake.

Parameters:
- WIDTH, 16, operand/result width in bits; legal range 4..64.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, do not override.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  synchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- T  input  WIDTH  operand 1 (stack top); captured when start is accepted.
- Y  input  WIDTH  operand 2 (Y bus); captured when start is accepted.
- funct  input  5  operation code; captured when start is accepted.
- busy  output  1  high from the cycle after acceptance until done.
- done  output  1  one-cycle pulse; results valid from this cycle.
- Result  output  WIDTH  low result, product low half, or quotient.
- ResultHi  output  WIDTH  product high half or remainder; 0 for single-cycle ops.
- flagC  output  1  carry/borrow/overflow, per op (see Behaviour).
- flagZ  output  1  Result == 0.
- flagN  output  1  Result[WIDTH-1].
- flagDZ  output  1  DIV attempted with Y == 0.

Behaviour:
- Interface decision: one clock; reset is synchronous and active-low.
- Reset (reset_n low at a rising edge): state IDLE; busy=0, done=0, Result=0, ResultHi=0, all flags 0.
- Reset mid-operation aborts the operation; no done pulse is produced.
- funct decode, casex, first match wins:
  - 00000 BYPASST: Result=T.
  - 00100 AND: Result=T&Y.
  - 01000 SUB: Result=T-Y.
  - 01100 OR: Result=T|Y.
  - 10000 ADD: Result=T+Y.
  - 10100 XOR: Result=T^Y.
  - 11000 NSUB: Result=Y-T.
  - 11100 BYPASSY: Result=Y.
  - xxx10 MULT.
  - xxx01 DIV.
  - anything else (including xxx11): BYPASST.
- Arithmetic is unsigned, modulo 2^WIDTH.
- flagC per op:
  - ADD: carry out of bit WIDTH-1.
  - SUB/NSUB: borrow, i.e. minuend < subtrahend.
  - MULT: ResultHi != 0.
  - DIV and logic ops: 0.
- States: IDLE, ITER, FIN.
- IDLE:
  - start=1 captures T/Y/funct at cycle 0 edge; done=0 in all other IDLE cycles.
  - Single-cycle op, or DIV with Y==0: go to FIN.
  - MULT or DIV with Y!=0: go to ITER, counter=WIDTH.
- ITER:
  - busy=1; one step per cycle; counter decrements.
  - When counter reaches 1 and that step completes, go to FIN.
  - Exactly WIDTH cycles are spent in ITER.
- FIN:
  - Outputs and flags update; done=1 for this one cycle; busy=0; next state IDLE.
- Latency from the start edge (cycle 0):
  - Single-cycle ops and DIV-by-zero: done in cycle 1.
  - MULT and DIV: done in cycle WIDTH+1.
  - start may be re-asserted in the cycle after done.
- start while busy or in FIN is ignored, not queued. Inputs are don't-care after capture.
- Results and flags hold from done until the next FIN; they are not cleared on a new start.
- MULT: 2*WIDTH-bit shift-add; {ResultHi,Result}=T*Y.
- DIV (restoring): Result=T/Y, ResultHi=T%Y.
- DIV with Y==0: Result = all ones, ResultHi=T, flagDZ=1, flagC=0, no iteration.
- flagDZ clears on the next completed op that is not a divide-by-zero.
- flagZ and flagN are evaluated on the registered Result only; ResultHi does not affect them.

Test Plan:
- WIDTH=16, ADD T=0xFFFF Y=0x0001, start in cycle 0 -> done in cycle 1; Result=0x0000, flagC=1, flagZ=1, flagN=0, busy never high.
- SUB T=0x0003 Y=0x0005 -> Result=0xFFFE, flagC=1, flagN=1, ResultHi=0, done in cycle 1.
- MULT T=0x1234 Y=0x0100 -> busy cycles 1..16, done in cycle 17; Result=0x3400, ResultHi=0x0012, flagC=1. Re-run with T=0xFFFF Y=0xFFFF -> ResultHi=0xFFFE, Result=0x0001.
- DIV T=100 Y=7 -> done in cycle 17, Result=14, ResultHi=2, flagDZ=0. Then DIV T=0x00AB Y=0 -> done in cycle 1, Result=0xFFFF, ResultHi=0x00AB, flagDZ=1.
- Start a MULT, pulse start with ADD in cycle 5 -> ignored; MULT result unchanged at cycle 17. Start a second MULT, drop reset_n in cycle 8 -> next cycle IDLE, all outputs 0, no done pulse.
- funct=5'b00011 T=0x5A5A -> BYPASST, Result=0x5A5A in cycle 1. Repeat the ADD and MULT checks at WIDTH=8 (MULT done in cycle 9) and WIDTH=32.
